// File: rtl/execute_pipe.sv
// execute_pipe: pipelined execute stage (ALU, branch target, store data)
// with an iterative shift-add multiplier, valid/ready handshakes on both
// sides, a registered EX/MEM output stage and a synchronous flush.
// Optional build macro EXECUTE_PIPE_FLAGS_EN adds the flags_M {N,Z,C,V} port.
module execute_pipe #(
    parameter int N      = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         zero_M,
    output logic [N-1:0] PCBranch_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] writeData_M,
`ifdef EXECUTE_PIPE_FLAGS_EN
    output logic [3:0]   flags_M,
`endif
    output logic         busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic {IDLE, MUL} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   op_a, op_b;
    logic [N-1:0]   alu_res;
    logic [N-1:0]   pc_branch;
    logic [N-1:0]   mul_a, mul_b, mul_acc, mul_acc_nx;
    logic [N-1:0]   mul_pcb, mul_wd;
    logic [CW-1:0]  cnt;
    logic           slot_free, accept, is_mul;
    logic           mul_last, mul_done, mul_step;

    assign op_a      = readData1_E;
    assign op_b      = AluSrc ? signImm_E : readData2_E;
    assign pc_branch = PC_E + {signImm_E[N-3:0], 2'b00};

    // Output slot can take a new result if empty or draining this cycle.
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && !flush && slot_free;
    assign accept    = in_valid && in_ready;
    assign is_mul    = MUL_EN && (AluControl == OP_MUL);
    assign busy      = (state == MUL);

    // Final iteration is held (not applied) until the output slot frees,
    // so the product is computed exactly once, on the completing edge.
    assign mul_last  = (state == MUL) && (cnt == CW'(N - 1));
    assign mul_done  = mul_last && slot_free;
    assign mul_step  = (state == MUL) && (!mul_last || slot_free);
    assign mul_acc_nx = mul_acc + (mul_b[0] ? mul_a : '0);

    // Single-cycle ALU result; MUL and unknown codes fall to zero here.
    always_comb begin
        alu_res = '0;
        case (AluControl)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_PASS: alu_res = op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            default: alu_res = '0;
        endcase
    end

`ifdef EXECUTE_PIPE_FLAGS_EN
    logic [N:0] add_w, sub_w;
    logic [3:0] alu_flags;
    logic [3:0] mul_flags;

    // {N,Z,C,V} for the single-cycle ops; C is no-borrow for SUB.
    always_comb begin
        add_w     = {1'b0, op_a} + {1'b0, op_b};
        sub_w     = {1'b0, op_a} + {1'b0, ~op_b} + {{N{1'b0}}, 1'b1};
        alu_flags = {alu_res[N-1], (alu_res == '0), 2'b00};
        case (AluControl)
            OP_ADD: begin
                alu_flags[1] = add_w[N];
                alu_flags[0] = (op_a[N-1] == op_b[N-1]) && (add_w[N-1] != op_a[N-1]);
            end
            OP_SUB: begin
                alu_flags[1] = sub_w[N];
                alu_flags[0] = (op_a[N-1] != op_b[N-1]) && (sub_w[N-1] != op_a[N-1]);
            end
            default: ;
        endcase
    end

    assign mul_flags = {mul_acc_nx[N-1], (mul_acc_nx == '0), 2'b00};
`endif

    // Next-state: flush always returns to IDLE and drops any MUL in flight.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && is_mul) state_nx = MUL;
            MUL:  if (mul_done)         state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Multiplier operand/accumulator registers: capture on accept, then shift-add.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
            mul_pcb <= '0;
            mul_wd  <= '0;
            cnt     <= '0;
        end else if (accept && is_mul) begin
            mul_a   <= op_a;
            mul_b   <= op_b;
            mul_acc <= '0;
            mul_pcb <= pc_branch;
            mul_wd  <= readData2_E;
            cnt     <= '0;
        end else if (mul_step && !flush) begin
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_acc <= mul_acc_nx;
            cnt     <= cnt + 1'b1;
        end
    end

    // EX/MEM register: load single-cycle result or finished product, else drain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            zero_M      <= 1'b0;
            PCBranch_M  <= '0;
            aluResult_M <= '0;
            writeData_M <= '0;
`ifdef EXECUTE_PIPE_FLAGS_EN
            flags_M     <= '0;
`endif
        end else if (flush) begin
            out_valid   <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid   <= 1'b1;
            zero_M      <= (alu_res == '0);
            PCBranch_M  <= pc_branch;
            aluResult_M <= alu_res;
            writeData_M <= readData2_E;
`ifdef EXECUTE_PIPE_FLAGS_EN
            flags_M     <= alu_flags;
`endif
        end else if (mul_done) begin
            out_valid   <= 1'b1;
            zero_M      <= (mul_acc_nx == '0);
            PCBranch_M  <= mul_pcb;
            aluResult_M <= mul_acc_nx;
            writeData_M <= mul_wd;
`ifdef EXECUTE_PIPE_FLAGS_EN
            flags_M     <= mul_flags;
`endif
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: a 64-bit instance for ALU/handshake
// scenarios and an 8-bit instance for multiplier and flush scenarios.
module tb_execute_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, out_ready, alusrc;
    logic        iv64, iv8, ir64, ir8, ov64, ov8, z64, z8, busy64, busy8;
    logic [3:0]  aluctl;
    logic [63:0] pc, imm, rd1, rd2;
    logic [63:0] pcb64, alu64, wd64;
    logic [7:0]  pcb8, alu8, wd8;
`ifdef EXECUTE_PIPE_FLAGS_EN
    logic [3:0]  fl64, fl8;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    execute_pipe #(.N(64), .MUL_EN(1'b1)) u_d64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv64), .in_ready(ir64),
        .AluSrc(alusrc), .AluControl(aluctl), .PC_E(pc), .signImm_E(imm),
        .readData1_E(rd1), .readData2_E(rd2), .out_valid(ov64), .out_ready(out_ready),
        .zero_M(z64), .PCBranch_M(pcb64), .aluResult_M(alu64), .writeData_M(wd64),
`ifdef EXECUTE_PIPE_FLAGS_EN
        .flags_M(fl64),
`endif
        .busy(busy64));

    execute_pipe #(.N(8), .MUL_EN(1'b1)) u_d8 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv8), .in_ready(ir8),
        .AluSrc(alusrc), .AluControl(aluctl), .PC_E(pc[7:0]), .signImm_E(imm[7:0]),
        .readData1_E(rd1[7:0]), .readData2_E(rd2[7:0]), .out_valid(ov8), .out_ready(out_ready),
        .zero_M(z8), .PCBranch_M(pcb8), .aluResult_M(alu8), .writeData_M(wd8),
`ifdef EXECUTE_PIPE_FLAGS_EN
        .flags_M(fl8),
`endif
        .busy(busy8));

    // advance one clock, land just after the edge
    task automatic cyc;
        @(posedge clk); #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic src, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] im, input logic [63:0] p);
        aluctl = op; alusrc = src; rd1 = a; rd2 = b; imm = im; pc = p;
    endtask

    task automatic test_reset;
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1; iv64 = 1'b0; iv8 = 1'b0;
        set_op(4'b0000, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
        cyc; cyc;
        reset = 1'b1; cyc;
        set_op(4'b1000, 1'b0, 64'd3, 64'd5, 64'd0, 64'h40);
        iv64 = 1'b1; iv8 = 1'b1;
        cyc;
        iv64 = 1'b0; iv8 = 1'b0;
        cyc; cyc;
        n_chk++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL reset_premul_busy8 got %b want 1", busy8); end
        n_chk++; if (busy64 !== 1'b1) begin n_fail++; $display("FAIL reset_premul_busy64 got %b want 1", busy64); end
        reset = 1'b0; cyc; cyc;
        reset = 1'b1; cyc;
        n_chk++; if (ov64 !== 1'b0 || ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b/%b want 0/0", ov64, ov8); end
        n_chk++; if (busy64 !== 1'b0 || busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b/%b want 0/0", busy64, busy8); end
        n_chk++; if (ir64 !== 1'b1 || ir8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b/%b want 1/1", ir64, ir8); end
        n_chk++; if (alu64 !== 64'd0 || pcb64 !== 64'd0 || wd64 !== 64'd0 || z64 !== 1'b0)
            begin n_fail++; $display("FAIL reset_outputs64 got alu=%h pcb=%h wd=%h z=%b want all 0", alu64, pcb64, wd64, z64); end
        n_chk++; if (alu8 !== 8'd0 || pcb8 !== 8'd0 || wd8 !== 8'd0 || z8 !== 1'b0)
            begin n_fail++; $display("FAIL reset_outputs8 got alu=%h pcb=%h wd=%h z=%b want all 0", alu8, pcb8, wd8, z8); end
`ifdef EXECUTE_PIPE_FLAGS_EN
        n_chk++; if (fl64 !== 4'd0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", fl64); end
`endif
    endtask

    task automatic test_add;
        out_ready = 1'b0;
        set_op(4'b0010, 1'b1, 64'd5, 64'hAA, 64'd3, 64'h100);
        iv64 = 1'b1; #1;
        n_chk++; if (ir64 !== 1'b1) begin n_fail++; $display("FAIL add_in_ready got %b want 1", ir64); end
        cyc;
        iv64 = 1'b0;
        n_chk++; if (ov64 !== 1'b1) begin n_fail++; $display("FAIL add_out_valid got %b want 1", ov64); end
        n_chk++; if (alu64 !== 64'd8) begin n_fail++; $display("FAIL add_result got %h want 8", alu64); end
        n_chk++; if (pcb64 !== 64'h10C) begin n_fail++; $display("FAIL add_pcbranch got %h want 10c", pcb64); end
        n_chk++; if (z64 !== 1'b0) begin n_fail++; $display("FAIL add_zero got %b want 0", z64); end
        n_chk++; if (wd64 !== 64'hAA) begin n_fail++; $display("FAIL add_writedata got %h want aa", wd64); end
        out_ready = 1'b1; cyc;
        n_chk++; if (ov64 !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b want 0", ov64); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  t_op [6];
        logic [63:0] t_a [6];
        logic [63:0] t_b [6];
        logic [63:0] t_e [6];
        logic [3:0]  t_f [6];
        t_op[0] = 4'b0001; t_a[0] = 64'h0F;    t_b[0] = 64'hF0;  t_e[0] = 64'hFF;                  t_f[0] = 4'b0000;
        t_op[1] = 4'b1100; t_a[1] = 64'h0;     t_b[1] = 64'h0;   t_e[1] = 64'hFFFF_FFFF_FFFF_FFFF; t_f[1] = 4'b1000;
        t_op[2] = 4'b0111; t_a[2] = 64'h77;    t_b[2] = 64'h1234; t_e[2] = 64'h1234;               t_f[2] = 4'b0000;
        t_op[3] = 4'b0010; t_a[3] = 64'hFFFF_FFFF_FFFF_FFFF; t_b[3] = 64'd1; t_e[3] = 64'd0;      t_f[3] = 4'b0110;
        t_op[4] = 4'b0110; t_a[4] = 64'd0;     t_b[4] = 64'd1;   t_e[4] = 64'hFFFF_FFFF_FFFF_FFFF; t_f[4] = 4'b1000;
        t_op[5] = 4'b0110; t_a[5] = 64'd3;     t_b[5] = 64'd5;   t_e[5] = 64'hFFFF_FFFF_FFFF_FFFE; t_f[5] = 4'b1000;
        out_ready = 1'b1;
        set_op(4'b0110, 1'b0, 64'd7, 64'd7, 64'd0, 64'd0);
        iv64 = 1'b1; #1;
        cyc;
        n_chk++; if (ov64 !== 1'b1 || alu64 !== 64'd0 || z64 !== 1'b1 || wd64 !== 64'd7)
            begin n_fail++; $display("FAIL b2b_sub got v=%b alu=%h z=%b wd=%h want 1/0/1/7", ov64, alu64, z64, wd64); end
`ifdef EXECUTE_PIPE_FLAGS_EN
        n_chk++; if (fl64 !== 4'b0110) begin n_fail++; $display("FAIL b2b_sub_flags got %b want 0110", fl64); end
`endif
        set_op(4'b0000, 1'b0, 64'hF0, 64'h0F, 64'd0, 64'd0);
        #1;
        n_chk++; if (ir64 !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b want 1", ir64); end
        cyc;
        n_chk++; if (ov64 !== 1'b1 || alu64 !== 64'd0 || z64 !== 1'b1 || wd64 !== 64'h0F)
            begin n_fail++; $display("FAIL b2b_and got v=%b alu=%h z=%b wd=%h want 1/0/1/f", ov64, alu64, z64, wd64); end
        for (int i = 0; i < 6; i++) begin
            set_op(t_op[i], 1'b0, t_a[i], t_b[i], 64'd0, 64'd0);
            cyc;
            n_chk++; if (ov64 !== 1'b1 || alu64 !== t_e[i] || z64 !== (t_e[i] == 64'd0))
                begin n_fail++; $display("FAIL b2b_op%0d got v=%b alu=%h z=%b want 1/%h/%b", i, ov64, alu64, z64, t_e[i], t_e[i] == 64'd0); end
`ifdef EXECUTE_PIPE_FLAGS_EN
            n_chk++; if (fl64 !== t_f[i]) begin n_fail++; $display("FAIL b2b_flags%0d got %b want %b", i, fl64, t_f[i]); end
`endif
        end
        iv64 = 1'b0; cyc;
        n_chk++; if (ov64 !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", ov64); end
    endtask

    task automatic run_mul8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
        out_ready = 1'b1;
        set_op(4'b1000, 1'b0, {56'd0, a}, {56'd0, b}, 64'd0, 64'd0);
        iv8 = 1'b1; #1;
        n_chk++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL mul_in_ready_idle got %b want 1", ir8); end
        cyc;
        iv8 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n_chk++; if (busy8 !== 1'b1 || ov8 !== 1'b0 || ir8 !== 1'b0)
                begin n_fail++; $display("FAIL mul_iter%0d got busy=%b v=%b rdy=%b want 1/0/0", k, busy8, ov8, ir8); end
            cyc;
        end
        n_chk++; if (ov8 !== 1'b1 || busy8 !== 1'b0 || alu8 !== exp || z8 !== (exp == 8'd0))
            begin n_fail++; $display("FAIL mul_result got v=%b busy=%b alu=%h z=%b want 1/0/%h", ov8, busy8, alu8, z8, exp); end
        cyc;
        n_chk++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL mul_drain got %b want 0", ov8); end
    endtask

    task automatic test_mul;
        run_mul8(8'd13, 8'd11, 8'h8F);
        run_mul8(8'hFF, 8'hFF, 8'h01);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        set_op(4'b0010, 1'b0, 64'd2, 64'd3, 64'd0, 64'd0);
        iv64 = 1'b1; #1;
        cyc;
        set_op(4'b0001, 1'b0, 64'h50, 64'h05, 64'd0, 64'd0);
        for (int k = 0; k < 5; k++) begin
            n_chk++; if (ov64 !== 1'b1 || alu64 !== 64'd5 || wd64 !== 64'd3 || ir64 !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold%0d got v=%b alu=%h wd=%h rdy=%b want 1/5/3/0", k, ov64, alu64, wd64, ir64); end
            cyc;
        end
        out_ready = 1'b1; #1;
        n_chk++; if (ir64 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", ir64); end
        cyc;
        iv64 = 1'b0;
        n_chk++; if (ov64 !== 1'b1 || alu64 !== 64'h55) begin n_fail++; $display("FAIL bp_next got v=%b alu=%h want 1/55", ov64, alu64); end
        cyc;
        n_chk++; if (ov64 !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", ov64); end
    endtask

    task automatic test_flush;
        out_ready = 1'b1;
        set_op(4'b1000, 1'b0, 64'd13, 64'd11, 64'd0, 64'd0);
        iv8 = 1'b1; #1;
        cyc;
        iv8 = 1'b0;
        cyc; cyc;
        flush = 1'b1;
        set_op(4'b0010, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0);
        iv8 = 1'b1; #1;
        n_chk++; if (ir8 !== 1'b0 || busy8 !== 1'b1) begin n_fail++; $display("FAIL flush_cycle got rdy=%b busy=%b want 0/1", ir8, busy8); end
        cyc;
        flush = 1'b0;
        n_chk++; if (busy8 !== 1'b0 || ov8 !== 1'b0) begin n_fail++; $display("FAIL flush_after got busy=%b v=%b want 0/0", busy8, ov8); end
        #1;
        n_chk++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", ir8); end
        cyc;
        iv8 = 1'b0;
        n_chk++; if (ov8 !== 1'b1 || alu8 !== 8'd2 || z8 !== 1'b0) begin n_fail++; $display("FAIL flush_add got v=%b alu=%h z=%b want 1/2/0", ov8, alu8, z8); end
        cyc;
    endtask

    task automatic test_unknown;
        out_ready = 1'b1;
        set_op(4'b1111, 1'b0, 64'd5, 64'd9, 64'd0, 64'd0);
        iv64 = 1'b1; #1;
        cyc;
        iv64 = 1'b0;
        n_chk++; if (ov64 !== 1'b1 || alu64 !== 64'd0 || z64 !== 1'b1 || wd64 !== 64'd9)
            begin n_fail++; $display("FAIL unknown_op got v=%b alu=%h z=%b wd=%h want 1/0/1/9", ov64, alu64, z64, wd64); end
`ifdef EXECUTE_PIPE_FLAGS_EN
        n_chk++; if (fl64 !== 4'b0100) begin n_fail++; $display("FAIL unknown_flags got %b want 0100", fl64); end
`endif
        cyc;
    endtask

    initial begin
        test_reset;
        test_add;
        test_back_to_back;
        test_mul;
        test_backpressure;
        test_flush;
        test_unknown;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle LEGv8 execute stage.
- Computes the branch target (PC + imm<<2), the ALU result, the zero flag and the store data.
- Adds a multi-cycle shift-add multiplier (MUL), valid/ready handshakes on both sides, a registered EX/MEM output stage and a synchronous flush.
- Sits between the ID/EX operand source and the memory stage.

Parameters:
N  64  datapath width in bits (≥8); MUL iterates N cycles.
MUL_EN  1  1 = MUL opcode supported; 0 = MUL treated as unknown opcode.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
flush  input  1  synchronous pipeline flush (branch mispredict/exception)
in_valid  input  1  operands and control valid
in_ready  output  1  stage can accept an operation this cycle
AluSrc  input  1  0: B = readData2_E; 1: B = signImm_E
AluControl  input  4  operation select
PC_E  input  N  PC of the instruction
signImm_E  input  N  sign-extended immediate
readData1_E  input  N  operand A
readData2_E  input  N  register operand / store data
out_valid  output  1  EX/MEM register holds a result
out_ready  input  1  memory stage consumes the result
zero_M  output  1  aluResult_M == 0
PCBranch_M  output  N  registered PC_E + (signImm_E << 2)
aluResult_M  output  N  registered ALU/MUL result
writeData_M  output  N  registered readData2_E
busy  output  1  multiplier iterating

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; out_valid=0, busy=0, zero_M=0, all N-bit outputs 0, iteration counter 0. Reset takes priority over flush and handshakes, including mid-MUL.
- Accept when in_valid && in_ready. in_ready = (state==IDLE) && !flush && (!out_valid || out_ready).
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (A−B)
  - 0111 pass B
  - 1100 NOR
  - 1000 MUL (low N bits of A×B)
  - Any other code: result 0, zero 1.
- Arithmetic is modulo 2^N. Shift-left-by-2 drops the top 2 bits. The PCBranch add wraps.
- Non-MUL op: 1-cycle latency. The result, zero, PCBranch and writeData load into the EX/MEM register at the accept edge; out_valid=1 next cycle.
- MUL, state machine IDLE→MUL→IDLE:
  - On accept, capture A, B, PCBranch and writeData; clear the accumulator; counter=0; busy=1.
  - Each MUL cycle: if B[0], accumulator += A; A<<=1; B>>=1; counter++.
  - After the N-th iteration (counter==N−1 edge), load the result into the EX/MEM register, set out_valid=1 and busy=0, and return to IDLE.
  - Accept-to-out_valid latency is N+1 cycles. in_ready=0 throughout.
- Output hold: while out_valid && !out_ready, all _M outputs are stable and in_ready=0 (no overwrite).
- Simultaneous drain and accept: with out_ready && out_valid and a new accept in the same cycle, the new result replaces the old one (back-to-back throughput of 1/cycle for non-MUL ops).
- MUL completion while out_valid && !out_ready: MUL stays in its final iteration state (counter frozen, busy=1) until the output slot frees.
- Flush: at the edge, out_valid←0, state←IDLE, busy←0; any MUL in flight is discarded. No operation is accepted in the flush cycle. Output data registers keep stale values (don't-care while out_valid=0).
- Zero flag is always derived from the registered N-bit result.

Optional Feature:
- Macro EXECUTE_PIPE_FLAGS_EN.
- When defined: extra output port flags_M[3:0] = {N,Z,C,V}, registered with aluResult_M and reset to 0.
  - ADD: C = carry out of bit N−1; V = signed overflow.
  - SUB: C = no-borrow (A ≥ B unsigned); V = signed overflow.
  - Logic, pass and MUL ops: C=V=0; N = result[N−1]; Z = zero.
- When not defined: the port is absent and no flag logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset: hold reset=0 two cycles mid-MUL, then release → out_valid=0, busy=0, in_ready=1, all _M outputs 0.
- N=64, ADD with AluSrc=1, readData1_E=5, signImm_E=3, PC_E=0x100 → one cycle later out_valid=1, aluResult_M=8, PCBranch_M=0x10C, zero_M=0.
- SUB 7−7, then AND 0xF0&0x0F back-to-back with out_ready=1 → results 0 (zero_M=1) and 0 (zero_M=1) on consecutive cycles with no bubble. With the flags macro: SUB flags = 0b0110.
- N=8, MUL 13×11 → busy=1 for 8 cycles, out_valid at cycle 9, aluResult_M=0x8F. Then 0xFF×0xFF → 0x01 (wrap).
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → outputs stable, in_ready=0, new in_valid ignored. Raise out_ready → next op accepted that same cycle.
- Flush at MUL iteration 3 → busy=0 and out_valid stays 0 next cycle. The following ADD 1+1 → aluResult_M=2. Also: unknown opcode 1111 → aluResult_M=0, zero_M=1.
